// File: rtl/sonic_ext_ctrl_pkg.sv
// sonic_ext_ctrl_pkg: shared constants and sizing helpers
// for the external-control input conditioner.
package sonic_ext_ctrl_pkg;

  localparam int WIDTH_DEF    = 4;
  localparam int BOUNCE_W_DEF = 8;
  localparam int SYNC_DEF     = 2;
  localparam int DEBOUNCE_DEF = 1024;

  // Counter width able to hold 0..cycles-1.
  function automatic int cnt_w(
    input int cycles
  );
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  // Value at which a w-bit bounce counter holds.
  function automatic int unsigned bounce_sat(
    input int unsigned w
  );
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sonic_ext_ctrl_conditioner_if.sv
// sonic_ext_ctrl_conditioner_if: raw control lines in,
// conditioned PIO levels and bounce statistics out.
interface sonic_ext_ctrl_conditioner_if
  import sonic_ext_ctrl_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int BOUNCE_W = BOUNCE_W_DEF
) ();

  logic [WIDTH-1:0]          raw_in;
  logic [WIDTH-1:0]          invert;
  logic                      clr_stats;
  logic [WIDTH-1:0]          out_port;
  logic [WIDTH-1:0]          changed;
  logic [WIDTH*BOUNCE_W-1:0] bounce_cnt;

  modport master (
    output raw_in,
    output invert,
    output clr_stats,
    input  out_port,
    input  changed,
    input  bounce_cnt
  );

  modport slave (
    input  raw_in,
    input  invert,
    input  clr_stats,
    output out_port,
    output changed,
    output bounce_cnt
  );

endinterface

// File: rtl/sonic_ext_ctrl_conditioner_debounce_chan.sv
// sonic_ext_ctrl_debounce_chan: one control bit through
// sync, polarity, debounce and bounce statistics.
module sonic_ext_ctrl_debounce_chan
  import sonic_ext_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int BOUNCE_W        = BOUNCE_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                raw_in,
  input  logic                invert,
  input  logic                clr_stats,
  output logic                out_q,
  output logic                changed_q,
  output logic [BOUNCE_W-1:0] bounce_cnt
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [BOUNCE_W-1:0] B_SAT =
    BOUNCE_W'(bounce_sat(BOUNCE_W));

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic                   cand;
  logic                   match;
  logic                   at_max;
  logic                   bounce;
  logic [CNT_W-1:0]       cnt;
  logic [BOUNCE_W-1:0]    bcnt;

  // Metastability chain for the asynchronous raw line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];
  assign cand   = sync_q ^ invert;
  assign match  = (cand == out_q);
  assign at_max = !match && (cnt == CNT_MAX);
  assign bounce = match && (cnt != '0);

  // Accept a new level only after it persists a full window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      out_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      unique case (1'b1)
        match: begin
          cnt <= '0;
        end
        at_max: begin
          cnt       <= '0;
          out_q     <= cand;
          changed_q <= 1'b1;
        end
        default: begin
          cnt <= cnt + 1'b1;
        end
      endcase
    end
  end

  // Count aborted changes; clear wins over an increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt <= '0;
    end else if (clr_stats) begin
      bcnt <= '0;
    end else if (bounce && (bcnt != B_SAT)) begin
      bcnt <= bcnt + 1'b1;
    end
  end

  assign bounce_cnt = bcnt;

endmodule

// File: rtl/sonic_ext_ctrl_conditioner.sv
// sonic_ext_ctrl_conditioner: conditions raw board control
// lines into clean levels for the Nios PIO in_port.
module sonic_ext_ctrl_conditioner
  import sonic_ext_ctrl_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int SYNC_STAGES     = SYNC_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int BOUNCE_W        = BOUNCE_W_DEF
) (
  input logic                         clk,
  input logic                         reset_n,
  sonic_ext_ctrl_conditioner_if.slave bus
);

  logic [WIDTH-1:0]          out_vec;
  logic [WIDTH-1:0]          chg_vec;
  logic [WIDTH*BOUNCE_W-1:0] bcnt_vec;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    sonic_ext_ctrl_debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BOUNCE_W        (BOUNCE_W)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw_in     (bus.raw_in[g]),
      .invert     (bus.invert[g]),
      .clr_stats  (bus.clr_stats),
      .out_q      (out_vec[g]),
      .changed_q  (chg_vec[g]),
      .bounce_cnt (bcnt_vec[g*BOUNCE_W +: BOUNCE_W])
    );
  end

  assign bus.out_port   = out_vec;
  assign bus.changed    = chg_vec;
  assign bus.bounce_cnt = bcnt_vec;

endmodule

// File: tb/tb_sonic_ext_ctrl_conditioner.sv
// tb_sonic_ext_ctrl_conditioner: directed scenarios plus
// random stimulus against a queue-based reference model.
module tb_sonic_ext_ctrl_conditioner;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 16;
  localparam int BW = 8;
  localparam int BMAX = (1 << BW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  sonic_ext_ctrl_conditioner_if #(
    .WIDTH    (W),
    .BOUNCE_W (BW)
  ) bus ();

  sonic_ext_ctrl_conditioner #(
    .WIDTH           (W),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC),
    .BOUNCE_W        (BW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]    out;
    logic [W-1:0]    chg;
    logic [W*BW-1:0] bc;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];

  logic [W-1:0] seen[$];
  logic [W-1:0] m_out;
  int           m_run[W];
  int           m_bc[W];

  task automatic check(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] req
  );
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h",
               nm, cyc, act, req);
    end
  endtask

  // Reference: raw seen SS edges late, level accepted after
  // DC consecutive disagreeing edges, aborts counted.
  always @(posedge clk) begin : model
    exp_t         e;
    logic [W-1:0] cand;
    logic [W-1:0] chg;
    bit           bnc;
    cyc++;
    chg = '0;
    if (!reset_n) begin
      seen = {};
      repeat (SS) seen.push_back('0);
      m_out = '0;
      for (int i = 0; i < W; i++) begin
        m_run[i] = 0;
        m_bc[i]  = 0;
      end
    end else begin
      cand = seen.pop_front() ^ bus.invert;
      seen.push_back(bus.raw_in);
      for (int i = 0; i < W; i++) begin
        bnc = (cand[i] == m_out[i]) && (m_run[i] > 0);
        if (cand[i] == m_out[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            m_out[i] = cand[i];
            chg[i]   = 1'b1;
            m_run[i] = 0;
          end
        end
        if (bus.clr_stats) m_bc[i] = 0;
        else if (bnc && m_bc[i] < BMAX) m_bc[i]++;
      end
    end
    e.out = m_out;
    e.chg = chg;
    e.cyc = cyc;
    for (int i = 0; i < W; i++)
      e.bc[i*BW +: BW] = BW'(m_bc[i]);
    exp_q.push_back(e);
  end

  // Monitor: every cycle the DUT presents a full output set.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_port", 64'(bus.out_port), 64'(e.out));
      check("changed", 64'(bus.changed), 64'(e.chg));
      check("bounce_cnt", 64'(bus.bounce_cnt), 64'(e.bc));
    end
  end

  // Count edges from now until the masked output matches.
  task automatic lat(
    input logic [W-1:0] mask,
    input logic [W-1:0] want,
    input int           req,
    input string        nm
  );
    int k;
    k = 0;
    while (k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if ((bus.out_port & mask) == want) break;
    end
    check(nm, 64'(k), 64'(req));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [W-1:0] r;
    bus.raw_in    = '0;
    bus.invert    = '0;
    bus.clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 64'(bus.out_port), 64'd0);
    check("rst_chg", 64'(bus.changed), 64'd0);
    check("rst_bc", 64'(bus.bounce_cnt), 64'd0);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // clean edge on ch0
    bus.raw_in = 4'b0001;
    lat(4'b0001, 4'b0001, 18, "s1_latency");
    check("s1_changed", 64'(bus.changed), 64'b0001);
    repeat (5) @(negedge clk);
    check("s1_bc0", 64'(bus.bounce_cnt[7:0]), 64'd0);

    // one bounce on ch1 before a held rise
    bus.raw_in = 4'b0011;
    repeat (5) @(negedge clk);
    bus.raw_in = 4'b0001;
    repeat (3) @(negedge clk);
    bus.raw_in = 4'b0011;
    lat(4'b0010, 4'b0010, 18, "s2_latency");
    repeat (3) @(negedge clk);
    check("s2_bc1", 64'(bus.bounce_cnt[15:8]), 64'd1);

    // polarity flip on ch2 with synchroniser settled
    bus.invert = 4'b0100;
    lat(4'b0100, 4'b0100, 16, "s3_latency");
    check("s3_changed", 64'(bus.changed), 64'b0100);
    repeat (3) @(negedge clk);

    // saturate ch3 bounce counter
    for (int n = 0; n < 300; n++) begin
      bus.raw_in[3] = 1'b1;
      repeat (3) @(negedge clk);
      bus.raw_in[3] = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("s4_sat", 64'(bus.bounce_cnt[31:24]), 64'd255);

    // clear lands on the same edge as one more bounce
    bus.raw_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    bus.raw_in[3] = 1'b0;
    repeat (2) @(negedge clk);
    bus.clr_stats = 1'b1;
    @(negedge clk);
    bus.clr_stats = 1'b0;
    check("s4_clr", 64'(bus.bounce_cnt[31:24]), 64'd0);
    repeat (3) @(negedge clk);

    // reset while ch3 is ten counts into its window
    bus.invert = 4'b0000;
    bus.raw_in = 4'b1111;
    repeat (12) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("s5_async_out", 64'(bus.out_port), 64'd0);
    check("s5_async_chg", 64'(bus.changed), 64'd0);
    check("s5_async_bc", 64'(bus.bounce_cnt), 64'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    lat(4'b1111, 4'b1111, 18, "s5_latency");
    repeat (2) @(negedge clk);

    // two channels rising together
    bus.raw_in = 4'b0000;
    repeat (25) @(negedge clk);
    bus.raw_in = 4'b1010;
    lat(4'b0010, 4'b0010, 18, "s6_latency");
    check("s6_out", 64'(bus.out_port), 64'b1010);
    check("s6_changed", 64'(bus.changed), 64'b1010);
    repeat (3) @(negedge clk);

    // random noise with quiet stretches
    r = bus.raw_in;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ((c % 400) < 300) begin
        for (int i = 0; i < W; i++)
          if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
      end
      bus.raw_in = r;
      if ($urandom_range(0, 199) == 0)
        bus.invert[$urandom_range(0, W-1)] ^= 1'b1;
      bus.clr_stats = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    bus.clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
